// File: rtl/ifu_inst_buf_pkg.sv
// Shared configuration for the IFU instruction buffer: widths, depth,
// constants and the packed {pc, instruction} entry carried through the FIFO.
package ifu_inst_buf_pkg;

  localparam int XLEN       = 32;
  localparam int IBUF_DEPTH = 4;
  localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH);

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic        TURE  = 1'b1;
  localparam logic        FALSE = 1'b0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ibuf_entry_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_ibuf_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and occupancy count.
// A synchronous clear empties it and takes priority over push and pop.
// The head entry is read combinationally and reads as zero when empty.
module ifu_ibuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Next pointers and count; DEPTH is a power of two so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a cleared cycle never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_inst_buf.sv
// Receive side of the IFU fetch interface. Pairs each synchronous-read
// IT-RAM word with the pc that fetched it, queues the pairs, and hands them
// to decode over valid/ready. load_hazerd stalls the IFU one entry early so
// the fetch already in flight always has a free slot.
module ifu_inst_buf
  import ifu_inst_buf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = IBUF_PTR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instruction,
  input  logic            flush_flag,
  output logic            load_hazerd,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instruction,
  output logic [PTR_W:0]  count
);

  localparam logic [PTR_W:0] HAZ_LEVEL  = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_vld_q, fetch_vld_d;
  logic            push, pop, empty;
  ibuf_entry_t     wr_entry, rd_entry;

  // Backpressure: flush never blocks the IFU from loading its flush address.
  always_comb begin
    load_hazerd = (count >= HAZ_LEVEL) && !flush_flag;
  end

  // The RAM word arriving next cycle is only usable if the IFU advanced past its pc.
  always_comb begin
    pc_d        = if_pc;
    fetch_vld_d = !load_hazerd && !flush_flag;
  end

  // Remember the fetching pc and whether its RAM word will be worth keeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= '0;
      fetch_vld_q <= FALSE;
    end else begin
      pc_q        <= pc_d;
      fetch_vld_q <= fetch_vld_d;
    end
  end

  assign push     = fetch_vld_q && !flush_flag;
  assign pop      = id_valid && id_ready;
  assign wr_entry = '{pc: pc_q, instr: if_instruction};

  ifu_ibuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ibuf_entry_t)),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (flush_flag),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .count_o (count),
    .empty_o (empty)
  );

  assign id_valid       = !empty;
  assign id_pc          = rd_entry.pc;
  assign id_instruction = rd_entry.instr;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == FULL_LEVEL) && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && (count == '0)));
  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst)
    is_aligned(pc_q));

endmodule

// File: tb/tb_ifu_inst_buf.sv
// Bench for ifu_inst_buf: an IFU/IT-RAM model drives the fetch side while a
// queue-based reference of the buffer predicts every decode-side output.
module tb_ifu_inst_buf;
  import ifu_inst_buf_pkg::*;

  localparam int DEPTH = IBUF_DEPTH;

  logic              clk;
  logic              rst;
  logic [XLEN-1:0]   if_pc;
  logic [31:0]       if_instruction;
  logic              flush_flag;
  logic              load_hazerd;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [31:0]       id_instruction;
  logic [IBUF_PTR_W:0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } refEntry_t;

  refEntry_t   refQ[$];
  bit          refFetchVld;
  logic [31:0] refPcQ;
  logic [31:0] flushAddr;
  int          vecCount  = 0;
  int          failCount = 0;
  bit          reached;

  ifu_inst_buf dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .flush_flag     (flush_flag),
    .load_hazerd    (load_hazerd),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .count          (count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Contents of the IT RAM: a distinct word for every pc.
  function automatic logic [31:0] ramWord(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all decode-side outputs with the reference queue.
  task automatic checkCycle();
    logic [31:0] ePc;
    logic [31:0] eIn;
    ePc = '0;
    eIn = '0;
    if (refQ.size() != 0) begin
      ePc = refQ[0].pc;
      eIn = refQ[0].instr;
    end
    checkOutput("id_valid", 64'(id_valid), 64'(refQ.size() != 0));
    checkOutput("count", 64'(count), 64'(refQ.size()));
    checkOutput("id_pc", 64'(id_pc), 64'(ePc));
    checkOutput("id_instruction", 64'(id_instruction), 64'(eIn));
    checkOutput("load_hazerd", 64'(load_hazerd),
                64'((refQ.size() >= DEPTH - 1) && !flush_flag));
  endtask

  // Advance one clock: update reference and IFU/RAM model at the edge, drive
  // the next cycle's inputs just after it, check outputs on the falling edge.
  task automatic applyStimulus(input bit rdy, input bit fl, input logic [31:0] fa);
    bit          haz;
    bit          pop;
    bit          push;
    logic [31:0] nextPc;
    logic [31:0] nextRam;
    @(posedge clk);
    haz  = (refQ.size() >= DEPTH - 1) && !flush_flag;
    pop  = (refQ.size() != 0) && id_ready;
    push = refFetchVld && !flush_flag;
    if (flush_flag) begin
      refQ.delete();
    end else begin
      if (pop)  refQ.delete(0);
      if (push) refQ.push_back('{pc: refPcQ, instr: if_instruction});
    end
    refFetchVld = !haz && !flush_flag;
    refPcQ      = if_pc;
    nextPc      = flush_flag ? flushAddr : (haz ? if_pc : if_pc + 32'd4);
    nextRam     = ramWord(if_pc);
    #1;
    if_instruction = nextRam;
    if_pc          = nextPc;
    flush_flag     = fl;
    flushAddr      = fa;
    id_ready       = rdy;
    @(negedge clk);
    checkCycle();
  endtask

  // Check that every output sits at its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_id_valid"}, 64'(id_valid), 64'd0);
    checkOutput({tag, "_load_hazerd"}, 64'(load_hazerd), 64'd0);
    checkOutput({tag, "_id_pc"}, 64'(id_pc), 64'd0);
    checkOutput({tag, "_id_instruction"}, 64'(id_instruction), 64'd0);
    checkOutput({tag, "_count"}, 64'(count), 64'd0);
  endtask

  // Asynchronous reset away from the clock edge; IFU restarts at pc 0.
  task automatic doReset();
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs("rst_async");
    refQ.delete();
    refFetchVld    = 1'b0;
    refPcQ         = '0;
    if_pc          = '0;
    if_instruction = '0;
    flush_flag     = 1'b0;
    flushAddr      = '0;
    id_ready       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("rst_held");
    rst = 1'b1;
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    rst            = 1'b0;
    if_pc          = '0;
    if_instruction = '0;
    flush_flag     = 1'b0;
    flushAddr      = '0;
    id_ready       = 1'b1;
    doReset();

    // Streaming with decode always ready.
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);

    // Decode stalls: buffer fills, IFU is held.
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);

    // Stall release drains in order and the stream continues.
    repeat (10) applyStimulus(1'b1, 1'b0, 32'h0);

    // Build up a few entries, then flush while pushing and popping.
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);

    // Mid-stream reset once two entries are queued.
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      if (refQ.size() == 2) reached = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("reach_count2", 64'(reached), 64'd1);
    checkOutput("pre_reset_count", 64'(count), 64'd2);
    doReset();
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);

    // Randomized ready and flush traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0,
                    32'($urandom_range(0, 16383)) << 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
